// File: rtl/epuin_axi_front_pkg.sv
// Shared types and constants for the EPUIN AXI front end: FSM state encoding,
// AXI response/burst codes and the window/address-step helpers.
package epuin_axi_front_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RADDR = 3'd1,
    ST_RDATA = 3'd2,
    ST_WADDR = 3'd3,
    ST_WDATA = 3'd4,
    ST_BRESP = 3'd5
  } epuin_front_state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  // Subtract-then-compare so a window touching the top of the address space still decodes.
  function automatic logic in_window(input logic [31:0] a, input logic [31:0] base,
                                     input logic [31:0] win);
    return (a >= base) && ((a - base) < win);
  endfunction

  function automatic logic [31:0] step_addr(input logic [31:0] a, input logic [1:0] burst);
    case (burst)
      BURST_FIXED:            return a;
      BURST_INCR, BURST_WRAP: return a + 32'd4;
      default:                return a + 32'd4;
    endcase
  endfunction

endpackage

// File: rtl/epuin_beat_ctr.sv
// Burst address/length/beat-count tracker shared by the read and write paths,
// with a registered window-hit flag that follows every stepped address.
module epuin_beat_ctr
  import epuin_axi_front_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter logic [31:0] WIN_BYTES = 32'd32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_i,
  input  logic [31:0] addr_i,
  input  logic [7:0]  len_i,
  input  logic [1:0]  burst_i,
  input  logic        step_i,
  output logic [31:0] addr_o,
  output logic [7:0]  cnt_o,
  output logic        last_o,
  output logic        enb_o
);

  logic [31:0] addr_q, addr_d;
  logic [7:0]  len_q, len_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [1:0]  burst_q, burst_d;
  logic        enb_q, enb_d;

  always_comb begin
    addr_d  = addr_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    burst_d = burst_q;
    enb_d   = enb_q;
    if (load_i) begin
      addr_d  = addr_i;
      len_d   = len_i;
      burst_d = burst_i;
      cnt_d   = 8'd0;
      enb_d   = in_window(addr_i, BASE_ADDR, WIN_BYTES);
    end else if (step_i) begin
      addr_d = step_addr(addr_q, burst_q);
      cnt_d  = cnt_q + 8'd1;
      enb_d  = in_window(addr_d, BASE_ADDR, WIN_BYTES);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= 32'd0;
      len_q   <= 8'd0;
      cnt_q   <= 8'd0;
      burst_q <= BURST_FIXED;
      enb_q   <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      burst_q <= burst_d;
      enb_q   <= enb_d;
    end
  end

  assign addr_o = addr_q;
  assign cnt_o  = cnt_q;
  assign last_o = (cnt_q == len_q);
  assign enb_o  = enb_q;

endmodule

// File: rtl/epuin_axi_front.sv
// AXI4 slave front end: turns AR/R/AW/W/B bursts into the single-cycle EPUIN
// handshake pulses plus CS/OE/addr/wdata for one buffer-wrapper window.
module epuin_axi_front
  import epuin_axi_front_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter logic [31:0] WIN_BYTES = 32'd32,
  parameter int          ID_W      = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [ID_W-1:0] s_awid_i,
  input  logic [31:0]     s_awaddr_i,
  input  logic [7:0]      s_awlen_i,
  input  logic [2:0]      s_awsize_i,
  input  logic [1:0]      s_awburst_i,
  input  logic            s_awvalid_i,
  output logic            s_awready_o,
  input  logic [31:0]     s_wdata_i,
  input  logic [3:0]      s_wstrb_i,
  input  logic            s_wlast_i,
  input  logic            s_wvalid_i,
  output logic            s_wready_o,
  output logic [ID_W-1:0] s_bid_o,
  output logic [1:0]      s_bresp_o,
  output logic            s_bvalid_o,
  input  logic            s_bready_i,
  input  logic [ID_W-1:0] s_arid_i,
  input  logic [31:0]     s_araddr_i,
  input  logic [7:0]      s_arlen_i,
  input  logic [2:0]      s_arsize_i,
  input  logic [1:0]      s_arburst_i,
  input  logic            s_arvalid_i,
  output logic            s_arready_o,
  output logic [ID_W-1:0] s_rid_o,
  output logic [31:0]     s_rdata_o,
  output logic [1:0]      s_rresp_o,
  output logic            s_rlast_o,
  output logic            s_rvalid_o,
  input  logic            s_rready_i,
  output logic            epuin_cs_o,
  output logic            epuin_oe_o,
  output logic [31:0]     epuin_addr_o,
  output logic [31:0]     epuin_wdata_o,
  output logic            epuin_arhns_o,
  output logic            epuin_awhns_o,
  output logic            epuin_rhns_o,
  output logic            epuin_whns_o,
  output logic            epuin_rdfin_o,
  output logic            epuin_wrfin_o,
  output logic            enb_o,
  input  logic            rvalid_i,
  input  logic [31:0]     rdata_i
);

  epuin_front_state_t state_q, state_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic               err_q, err_d;
  logic               last, step, load;
  logic [31:0]        beat_addr;

  // Full-word only and fixed 32-bit beats, so size and strobes carry no information here.
  logic unused_ok;
  assign unused_ok = ^{s_wstrb_i, s_awsize_i, s_arsize_i};

  assign load = epuin_arhns_o | epuin_awhns_o;

  epuin_beat_ctr #(.BASE_ADDR(BASE_ADDR), .WIN_BYTES(WIN_BYTES)) u_beat_ctr (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (load),
    .addr_i  (s_arvalid_i ? s_araddr_i : s_awaddr_i),
    .len_i   (s_arvalid_i ? s_arlen_i : s_awlen_i),
    .burst_i (s_arvalid_i ? s_arburst_i : s_awburst_i),
    .step_i  (step),
    .addr_o  (beat_addr),
    .cnt_o   (),
    .last_o  (last),
    .enb_o   (enb_o)
  );

  always_comb begin
    state_d       = state_q;
    id_d          = id_q;
    err_d         = err_q;
    step          = 1'b0;
    s_awready_o   = 1'b0;
    s_arready_o   = 1'b0;
    s_wready_o    = 1'b0;
    s_bvalid_o    = 1'b0;
    s_bresp_o     = RESP_OKAY;
    s_rvalid_o    = 1'b0;
    s_rdata_o     = 32'd0;
    s_rresp_o     = RESP_OKAY;
    s_rlast_o     = 1'b0;
    epuin_cs_o    = 1'b0;
    epuin_oe_o    = 1'b0;
    epuin_wdata_o = 32'd0;
    epuin_arhns_o = 1'b0;
    epuin_awhns_o = 1'b0;
    epuin_rhns_o  = 1'b0;
    epuin_whns_o  = 1'b0;
    epuin_rdfin_o = 1'b0;
    epuin_wrfin_o = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // IDLE is also the reset state, so the readies must be masked while rst_n is low.
        if (rst_n) begin
          s_arready_o = 1'b1;
          s_awready_o = !s_arvalid_i;
          if (s_arvalid_i) begin
            epuin_arhns_o = 1'b1;
            id_d          = s_arid_i;
            state_d       = ST_RADDR;
          end else if (s_awvalid_i) begin
            epuin_awhns_o = 1'b1;
            id_d          = s_awid_i;
            err_d         = 1'b0;
            state_d       = ST_WADDR;
          end
        end
      end
      ST_RADDR: begin
        epuin_cs_o = 1'b1;
        epuin_oe_o = 1'b1;
        state_d    = ST_RDATA;
      end
      ST_RDATA: begin
        epuin_cs_o   = 1'b1;
        epuin_oe_o   = 1'b1;
        s_rvalid_o   = enb_o ? rvalid_i : 1'b1;
        s_rdata_o    = enb_o ? rdata_i : 32'd0;
        s_rresp_o    = enb_o ? RESP_OKAY : RESP_DECERR;
        s_rlast_o    = last;
        epuin_rhns_o = s_rvalid_o & s_rready_i;
        if (epuin_rhns_o) begin
          if (last) begin
            epuin_rdfin_o = 1'b1;
            state_d       = ST_IDLE;
          end else begin
            step    = 1'b1;
            state_d = ST_RADDR;
          end
        end
      end
      ST_WADDR: begin
        epuin_cs_o = 1'b1;
        state_d    = ST_WDATA;
      end
      ST_WDATA: begin
        epuin_cs_o    = 1'b1;
        s_wready_o    = 1'b1;
        epuin_wdata_o = s_wdata_i;
        epuin_whns_o  = s_wvalid_i;
        if (s_wvalid_i) begin
          step = 1'b1;
          if (!enb_o) err_d = 1'b1;
          if (s_wlast_i) begin
            epuin_wrfin_o = 1'b1;
            state_d       = ST_BRESP;
          end
        end
      end
      ST_BRESP: begin
        s_bvalid_o = 1'b1;
        s_bresp_o  = err_q ? RESP_DECERR : RESP_OKAY;
        if (s_bready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      id_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      err_q   <= err_d;
    end
  end

  assign s_rid_o      = id_q;
  assign s_bid_o      = id_q;
  assign epuin_addr_o = beat_addr;

endmodule

// File: tb/tb_epuin_axi_front.sv
// Directed bench for epuin_axi_front: a table of single-beat reads plus
// hand-written multi-cycle sequences for writes, arbitration, window edge and reset.
module tb_epuin_axi_front;
  import epuin_axi_front_pkg::*;

  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam logic [31:0] WIN  = 32'd32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] awid = 0, arid = 0, bid, rid;
  logic [31:0] awaddr = 0, araddr = 0, wdata = 0, rdata_o, rdata_i = 0, e_addr, e_wdata;
  logic [7:0] awlen = 0, arlen = 0;
  logic [1:0] awburst = 0, arburst = 0, bresp, rresp;
  logic awvalid = 0, wlast = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0, rvalid_i = 0;
  logic awready, wready, bvalid, arready, rlast, rvalid_o;
  logic cs, oe, arhns, awhns, rhns, whns, rdfin, wrfin, enb;

  int n_vec = 0;
  int n_err = 0;
  int c_arhns = 0, c_awhns = 0, c_whns = 0, c_rdfin = 0, c_wrfin = 0;

  always #5 clk = ~clk;

  epuin_axi_front #(.BASE_ADDR(BASE), .WIN_BYTES(WIN), .ID_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_awid_i(awid), .s_awaddr_i(awaddr), .s_awlen_i(awlen), .s_awsize_i(3'd2),
    .s_awburst_i(awburst), .s_awvalid_i(awvalid), .s_awready_o(awready),
    .s_wdata_i(wdata), .s_wstrb_i(4'hF), .s_wlast_i(wlast), .s_wvalid_i(wvalid),
    .s_wready_o(wready),
    .s_bid_o(bid), .s_bresp_o(bresp), .s_bvalid_o(bvalid), .s_bready_i(bready),
    .s_arid_i(arid), .s_araddr_i(araddr), .s_arlen_i(arlen), .s_arsize_i(3'd2),
    .s_arburst_i(arburst), .s_arvalid_i(arvalid), .s_arready_o(arready),
    .s_rid_o(rid), .s_rdata_o(rdata_o), .s_rresp_o(rresp), .s_rlast_o(rlast),
    .s_rvalid_o(rvalid_o), .s_rready_i(rready),
    .epuin_cs_o(cs), .epuin_oe_o(oe), .epuin_addr_o(e_addr), .epuin_wdata_o(e_wdata),
    .epuin_arhns_o(arhns), .epuin_awhns_o(awhns), .epuin_rhns_o(rhns), .epuin_whns_o(whns),
    .epuin_rdfin_o(rdfin), .epuin_wrfin_o(wrfin),
    .enb_o(enb), .rvalid_i(rvalid_i), .rdata_i(rdata_i)
  );

  // Pulse tallies sampled mid-cycle, away from the input drive point.
  always @(negedge clk) begin
    if (arhns) c_arhns++;
    if (awhns) c_awhns++;
    if (whns)  c_whns++;
    if (rdfin) c_rdfin++;
    if (wrfin) c_wrfin++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  burst;
    logic        rv_in;
    logic [31:0] rdata;
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
    logic        exp_enb;
  } rd_vec_t;

  rd_vec_t vecs [5];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{BASE + 32'h8,  BURST_INCR,  1'b1, 32'hA5A5_0001, 32'hA5A5_0001, RESP_OKAY,   1'b1};
    vecs[1] = '{BASE + 32'h1C, BURST_INCR,  1'b1, 32'h1234_5678, 32'h1234_5678, RESP_OKAY,   1'b1};
    vecs[2] = '{BASE + 32'h20, BURST_INCR,  1'b0, 32'hDEAD_BEEF, 32'h0,         RESP_DECERR, 1'b0};
    vecs[3] = '{BASE - 32'h4,  BURST_FIXED, 1'b0, 32'h0000_0011, 32'h0,         RESP_DECERR, 1'b0};
    vecs[4] = '{BASE,          BURST_WRAP,  1'b1, 32'hCAFE_F00D, 32'hCAFE_F00D, RESP_OKAY,   1'b1};

    // Reset state
    smp();
    chk("rst_arready", arready, 0); chk("rst_awready", awready, 0);
    chk("rst_bvalid", bvalid, 0);   chk("rst_rvalid", rvalid_o, 0);
    chk("rst_cs", cs, 0);           chk("rst_enb", enb, 0);
    chk("rst_addr", e_addr, 0);
    nxt(); rst_n = 1'b1;
    smp(); chk("idle_arready", arready, 1); chk("idle_awready", awready, 1);

    // Single-beat read table; the wrapper answers two cycles after arhns
    rready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      nxt();
      arid = 8'h10 + 8'(i); araddr = vecs[i].addr; arlen = 0; arburst = vecs[i].burst;
      arvalid = 1'b1;
      smp(); chk("rd_arhns", arhns, 1); chk("rd_arready", arready, 1);
      nxt(); arvalid = 1'b0;
      smp(); chk("rd_raddr_cs", cs, 1); chk("rd_raddr_oe", oe, 1);
      chk("rd_raddr_addr", e_addr, vecs[i].addr); chk("rd_raddr_rvalid", rvalid_o, 0);
      chk("rd_enb", enb, 32'(vecs[i].exp_enb));
      nxt(); rvalid_i = vecs[i].rv_in; rdata_i = vecs[i].rdata;
      smp(); chk("rd_rvalid", rvalid_o, 1); chk("rd_rdata", rdata_o, vecs[i].exp_data);
      chk("rd_rresp", rresp, 32'(vecs[i].exp_resp)); chk("rd_rlast", rlast, 1);
      chk("rd_rid", rid, 32'(8'h10 + 8'(i))); chk("rd_rhns", rhns, 1); chk("rd_rdfin", rdfin, 1);
      nxt(); rvalid_i = 1'b0;
      smp(); chk("rd_back_idle", arready, 1);
    end
    nxt();
    chk("rd_arhns_count", c_arhns, 5); chk("rd_rdfin_count", c_rdfin, 5);

    // INCR write len=3 with BREADY held off for 5 cycles
    awid = 8'h5A; awaddr = BASE; awlen = 3; awburst = BURST_INCR; awvalid = 1'b1;
    smp(); chk("wr_awhns", awhns, 1);
    nxt(); awvalid = 1'b0;
    smp(); chk("wr_waddr_cs", cs, 1); chk("wr_waddr_oe", oe, 0); chk("wr_waddr_wready", wready, 0);
    nxt(); wvalid = 1'b1; wdata = 32'd1; wlast = 1'b0;
    for (int k = 0; k < 4; k++) begin
      smp(); chk("wr_whns", whns, 1); chk("wr_addr", e_addr, BASE + 32'(4 * k));
      chk("wr_wdata", e_wdata, 32'(k + 1)); chk("wr_wrfin", wrfin, 32'(k == 3));
      nxt();
      if (k < 3) begin wdata = 32'(k + 2); wlast = (k == 2); end
      else begin wvalid = 1'b0; wlast = 1'b0; end
    end
    for (int j = 0; j < 5; j++) begin
      smp(); chk("wr_bvalid_hold", bvalid, 1); chk("wr_bid", bid, 32'h5A); chk("wr_bresp", bresp, RESP_OKAY);
      nxt();
    end
    bready = 1'b1;
    smp(); chk("wr_bvalid_last", bvalid, 1);
    nxt(); bready = 1'b0;
    smp(); chk("wr_bvalid_clear", bvalid, 0); chk("wr_awready_idle", awready, 1);
    chk("wr_whns_count", c_whns, 4); chk("wr_wrfin_count", c_wrfin, 1);

    // AR and AW together: the read goes first, AW waits for IDLE
    nxt();
    arid = 8'h21; araddr = BASE + 32'h10; arlen = 0; arburst = BURST_INCR; arvalid = 1'b1;
    awid = 8'h22; awaddr = BASE + 32'h14; awlen = 0; awburst = BURST_INCR; awvalid = 1'b1;
    smp(); chk("arb_arhns", arhns, 1); chk("arb_awhns", awhns, 0); chk("arb_awready", awready, 0);
    nxt(); arvalid = 1'b0;
    smp(); chk("arb_raddr_awready", awready, 0); chk("arb_raddr_awhns", awhns, 0);
    nxt(); rvalid_i = 1'b1; rdata_i = 32'h33;
    smp(); chk("arb_rhns", rhns, 1); chk("arb_rdata", rdata_o, 32'h33); chk("arb_rdata_awready", awready, 0);
    nxt(); rvalid_i = 1'b0;
    smp(); chk("arb_idle_awready", awready, 1); chk("arb_idle_awhns", awhns, 1);
    nxt(); awvalid = 1'b0;
    smp();
    nxt(); wvalid = 1'b1; wlast = 1'b1; wdata = 32'h44;
    smp(); chk("arb_wrfin", wrfin, 1); chk("arb_waddr", e_addr, BASE + 32'h14);
    nxt(); wvalid = 1'b0; wlast = 1'b0; bready = 1'b1;
    smp(); chk("arb_bvalid", bvalid, 1); chk("arb_bid", bid, 32'h22);
    nxt(); bready = 1'b0;
    smp(); chk("arb_bvalid_clear", bvalid, 0);

    // Read len=1 straddling the top of the window
    nxt();
    arid = 8'h31; araddr = BASE + WIN - 32'd4; arlen = 1; arburst = BURST_INCR; arvalid = 1'b1;
    smp();
    nxt(); arvalid = 1'b0; rvalid_i = 1'b1; rdata_i = 32'h77;
    smp(); chk("edge_b0_enb", enb, 1);
    nxt();
    smp(); chk("edge_b0_rdata", rdata_o, 32'h77); chk("edge_b0_rresp", rresp, RESP_OKAY); chk("edge_b0_rlast", rlast, 0);
    nxt(); rvalid_i = 1'b0;
    smp(); chk("edge_b1_enb", enb, 0); chk("edge_b1_addr", e_addr, BASE + WIN);
    nxt();
    smp(); chk("edge_b1_rvalid", rvalid_o, 1); chk("edge_b1_rdata", rdata_o, 0);
    chk("edge_b1_rresp", rresp, RESP_DECERR); chk("edge_b1_rlast", rlast, 1); chk("edge_b1_rdfin", rdfin, 1);

    // FIXED read len=2: address constant, RADDR entered once per beat
    nxt();
    arid = 8'h41; araddr = BASE + 32'h8; arlen = 2; arburst = BURST_FIXED; arvalid = 1'b1;
    smp();
    nxt(); arvalid = 1'b0; rvalid_i = 1'b1; rdata_i = 32'h55;
    for (int b = 0; b < 3; b++) begin
      smp(); chk("fix_raddr_addr", e_addr, BASE + 32'h8); chk("fix_raddr_state", rvalid_o, 0);
      nxt();
      smp(); chk("fix_rdata_rvalid", rvalid_o, 1); chk("fix_rlast", rlast, 32'(b == 2));
      chk("fix_rdata_addr", e_addr, BASE + 32'h8);
      nxt();
    end
    rvalid_i = 1'b0;
    smp(); chk("fix_back_idle", arready, 1);

    // Reset asserted during beat 2 of a 4-beat write
    nxt();
    awid = 8'h61; awaddr = BASE; awlen = 3; awburst = BURST_INCR; awvalid = 1'b1;
    smp();
    nxt(); awvalid = 1'b0;
    smp();
    nxt(); wvalid = 1'b1; wdata = 32'hA0; wlast = 1'b0;
    smp();
    nxt(); wdata = 32'hA1;
    smp();
    nxt(); wdata = 32'hA2;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_wready", wready, 0); chk("mid_rst_whns", whns, 0); chk("mid_rst_cs", cs, 0);
    chk("mid_rst_addr", e_addr, 0); chk("mid_rst_enb", enb, 0); chk("mid_rst_awready", awready, 0);
    chk("mid_rst_bvalid", bvalid, 0);
    wvalid = 1'b0;
    nxt(); rst_n = 1'b1;
    smp(); chk("post_rst_awready", awready, 1); chk("post_rst_bvalid", bvalid, 0);
    nxt();
    smp(); chk("post_rst_bvalid2", bvalid, 0);
    nxt();
    chk("tot_arhns", c_arhns, 8); chk("tot_awhns", c_awhns, 3);
    chk("tot_whns", c_whns, 7);   chk("tot_rdfin", c_rdfin, 8);
    chk("tot_wrfin", c_wrfin, 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
